// File: rtl/core_tile_sequencer.sv
// core_tile_sequencer
//   Generates the 49-bit instruction word for one weight-stationary tile of
//   the core. The steps are: weights xmem -> L0, kernel load into the PE
//   array, a settle gap, activations xmem -> L0, execute, and a drain of
//   OFIFO psum rows into pmem. The only feedback from the core is ofifo_valid.
//
// Ports
//   clk, reset   clock; asynchronous active-low reset
//   start        one-cycle request, sampled only in IDLE
//   len          number of activation vectors (= psum rows produced)
//   w_base       xmem address of the first weight vector
//   x_base       xmem address of the first activation vector
//   p_base       pmem address of the first psum write
//   acc_en       SFU accumulate enable, latched at start
//   relu_en      SFU ReLU enable, latched at start
//   ofifo_valid  core OFIFO holds a complete psum row
//   inst         registered core instruction word
//   busy         high from the cycle after an accepted start until DONE
//   done         one-cycle pulse at tile completion
//   dbg_state    current FSM state (encoding of state_t)
//
// OFIFO handshake: ofifo_valid acts as "valid" and inst[6] (ofifo_rd) as
// "ready". A row is popped on a cycle where ofifo_rd is high. Because inst
// is registered, ofifo_rd follows the ofifo_valid seen one cycle earlier.
// The rd_cnt < len cap stops the sequencer from popping more rows than the
// tile produced.

module core_tile_sequencer #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_bw = 11,
  parameter int len_bw  = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [len_bw-1:0]  len,
  input  logic [addr_bw-1:0] w_base,
  input  logic [addr_bw-1:0] x_base,
  input  logic [addr_bw-1:0] p_base,
  input  logic               acc_en,
  input  logic               relu_en,
  input  logic               ofifo_valid,
  output logic [48:0]        inst,
  output logic               busy,
  output logic               done,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_W_L0, S_W_LOAD, S_W_GAP, S_X_L0, S_EXEC, S_DRAIN, S_DONE
  } state_t;

  // The phase counter must reach len (X_L0 has len+1 cycles) and row+col-1.
  localparam int gw = $clog2(row + col + 1);
  localparam int cw = (len_bw + 1 > gw) ? len_bw + 1 : gw;

  state_t             state, nxt_state;
  logic [cw-1:0]      cnt, nxt_cnt;
  logic [len_bw-1:0]  len_q, nxt_len;
  logic [len_bw-1:0]  rd_cnt, nxt_rd_cnt;
  // wr_cnt counts pmem writes already scheduled. It is incremented on the
  // edge that schedules a write, so during the final write cycle it equals len.
  logic [len_bw-1:0]  wr_cnt, nxt_wr_cnt;
  logic [addr_bw-1:0] w_q, x_q, p_q, nxt_w, nxt_x, nxt_p;
  logic               acc_q, relu_q, nxt_acc, nxt_relu;
  logic [48:0]        nxt_inst;
  logic               nxt_busy, nxt_done;
  logic               rd_issue, wr_now;

  always_comb begin
    rd_issue   = (state == S_DRAIN) && ofifo_valid && (rd_cnt < len_q);
    wr_now     = (state == S_DRAIN) && !inst[32];
    nxt_state  = state;
    nxt_cnt    = cnt;
    nxt_len    = len_q;
    nxt_rd_cnt = rd_cnt;
    nxt_wr_cnt = wr_cnt;
    nxt_w      = w_q;
    nxt_x      = x_q;
    nxt_p      = p_q;
    nxt_acc    = acc_q;
    nxt_relu   = relu_q;

    case (state)
      S_IDLE: begin
        if (start) begin
          nxt_len    = len;
          nxt_w      = w_base;
          nxt_x      = x_base;
          nxt_p      = p_base;
          nxt_acc    = acc_en;
          nxt_relu   = relu_en;
          nxt_cnt    = '0;
          nxt_rd_cnt = '0;
          nxt_wr_cnt = '0;
          nxt_state  = (len == '0) ? S_DONE : S_W_L0;
        end
      end
      S_W_L0: begin
        if (cnt == cw'(col)) begin
          nxt_state = S_W_LOAD;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + cw'(1);
        end
      end
      S_W_LOAD: begin
        if (cnt == cw'(col - 1)) begin
          nxt_state = S_W_GAP;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + cw'(1);
        end
      end
      S_W_GAP: begin
        if (cnt == cw'(row + col - 1)) begin
          nxt_state = S_X_L0;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + cw'(1);
        end
      end
      S_X_L0: begin
        if (cnt == cw'(len_q)) begin
          nxt_state = S_EXEC;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + cw'(1);
        end
      end
      S_EXEC: begin
        if (cnt == cw'(len_q - len_bw'(1))) begin
          nxt_state = S_DRAIN;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + cw'(1);
        end
      end
      S_DRAIN: begin
        if (rd_issue) nxt_rd_cnt = rd_cnt + len_bw'(1);
        // A pop this cycle means the pmem write goes out next cycle.
        if (inst[6]) nxt_wr_cnt = wr_cnt + len_bw'(1);
        if (wr_now && (wr_cnt == len_q)) nxt_state = S_DONE;
      end
      S_DONE: nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase

    nxt_busy = (nxt_state != S_IDLE) && (nxt_state != S_DONE);
    nxt_done = (nxt_state == S_DONE);

    // Build the word the core sees next cycle. All CEN/WEN bits default high.
    nxt_inst     = '0;
    nxt_inst[18] = 1'b1;
    nxt_inst[19] = 1'b1;
    nxt_inst[31] = 1'b1;
    nxt_inst[32] = 1'b1;
    nxt_inst[44] = 1'b1;
    nxt_inst[45] = 1'b1;
    if (nxt_busy) nxt_inst[47:46] = {nxt_relu, nxt_acc};

    case (nxt_state)
      S_W_L0: begin
        if (nxt_cnt < cw'(col)) begin
          nxt_inst[19]             = 1'b0;
          nxt_inst[7 +: addr_bw]   = nxt_w + addr_bw'(nxt_cnt);
        end
        // L0 write trails the xmem read by the SRAM's one-cycle latency.
        if (nxt_cnt != '0) nxt_inst[2] = 1'b1;
      end
      S_W_LOAD: begin
        nxt_inst[3] = 1'b1;
        nxt_inst[1] = 1'b1;
      end
      S_X_L0: begin
        if (nxt_cnt < cw'(nxt_len)) begin
          nxt_inst[19]             = 1'b0;
          nxt_inst[7 +: addr_bw]   = nxt_x + addr_bw'(nxt_cnt);
        end
        if (nxt_cnt != '0) nxt_inst[2] = 1'b1;
      end
      S_EXEC: begin
        nxt_inst[3] = 1'b1;
        nxt_inst[0] = 1'b1;
      end
      S_DRAIN: begin
        if (rd_issue) nxt_inst[6] = 1'b1;
        if (inst[6]) begin
          nxt_inst[32]             = 1'b0;
          nxt_inst[31]             = 1'b0;
          nxt_inst[20 +: addr_bw]  = p_q + addr_bw'(wr_cnt);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      len_q  <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
      w_q    <= '0;
      x_q    <= '0;
      p_q    <= '0;
      acc_q  <= 1'b0;
      relu_q <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      inst   <= 49'h3001_800C_0000;
    end else begin
      state  <= nxt_state;
      cnt    <= nxt_cnt;
      len_q  <= nxt_len;
      rd_cnt <= nxt_rd_cnt;
      wr_cnt <= nxt_wr_cnt;
      w_q    <= nxt_w;
      x_q    <= nxt_x;
      p_q    <= nxt_p;
      acc_q  <= nxt_acc;
      relu_q <= nxt_relu;
      busy   <= nxt_busy;
      done   <= nxt_done;
      inst   <= nxt_inst;
    end
  end

  assign dbg_state = state;

endmodule

// File: doc/core_tile_sequencer.md
Name: core_tile_sequencer

Overview:
- Instruction sequencer directly upstream of the core; drives its full 49-bit inst word for one weight-stationary tile.
- Tile steps: load weights from xmem into L0, kernel-load the PE array, stream activations, execute, and drain OFIFO psums into pmem.
- Replaces testbench-driven inst generation; the core's ofifo_valid is its only feedback.

Parameters:
- row, 8, PE array rows (L0 lanes).
- col, 8, PE array columns (weight vectors loaded).
- addr_bw, 11, SRAM address width (2048 words).
- len_bw, 11, width of the activation-vector count.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- len  input  len_bw  number of activation vectors (= psum vectors produced).
- w_base  input  addr_bw  xmem address of the first weight vector.
- x_base  input  addr_bw  xmem address of the first activation vector.
- p_base  input  addr_bw  pmem address of the first psum write.
- acc_en  input  1  SFU accumulate enable, latched at start.
- relu_en  input  1  SFU ReLU enable, latched at start.
- ofifo_valid  input  1  core OFIFO holds a complete psum row.
- inst  output  49  core instruction word, fully registered.
- busy  output  1  high from the cycle after an accepted start until DONE exits.
- done  output  1  one-cycle pulse at tile completion.

Behaviour:
- inst field map:
  - [0] execute, [1] kernel load, [2] l0_wr, [3] l0_rd, [4] ififo_rd, [5] ififo_wr, [6] ofifo_rd.
  - [17:7] xmem A, [18] xmem WEN, [19] xmem CEN.
  - [30:20] pmem A, [31] pmem WEN, [32] pmem CEN.
  - [43:33] wmem A, [44] wmem WEN, [45] wmem CEN.
  - [46] accumulate, [47] relu, [48] mode.
  - CEN and WEN are active-low.
- IDLE inst value: bits 18, 19, 31, 32, 44, 45 = 1; all other bits 0.
- Reset (async, active-low): inst = IDLE value, busy = 0, done = 0, all counters 0, state = IDLE. Mid-tile reset aborts immediately; no partial resume.
- inst[48] = 0 always (weight-stationary). inst[47:46] = latched {relu_en, acc_en} while busy, 0 otherwise. ififo and wmem bits are never asserted.
- FSM: IDLE -> W_L0 -> W_LOAD -> W_GAP -> X_L0 -> EXEC -> DRAIN -> DONE -> IDLE.
- IDLE: start=1 with len != 0 latches len, bases and cfg, then enters W_L0. start=1 with len = 0 goes straight to DONE (one done pulse, no SRAM or L0 activity). start=0 stays in IDLE.
- W_L0 (col+1 cycles):
  - Phase cycles 0..col-1: xmem CEN=0, WEN=1, A = w_base+i.
  - Cycles 1..col: l0_wr = 1 (one-cycle SRAM read latency).
- W_LOAD (col cycles): l0_rd = 1 and inst[1] = 1.
- W_GAP (row+col cycles): inst bits 0-6 = 0 so weights settle.
- X_L0 (len+1 cycles): same pattern as W_L0, with address x_base+i and i over 0..len-1.
- EXEC (len cycles): l0_rd = 1 and inst[0] = 1.
- DRAIN:
  - Every cycle with ofifo_valid = 1 and rd_cnt < len: ofifo_rd = 1 and rd_cnt++.
  - The cycle after each ofifo_rd: pmem CEN=0, WEN=0, A = p_base+wr_cnt, then wr_cnt++.
  - Exits to DONE when wr_cnt reaches len.
  - ofifo_valid stuck low stalls DRAIN indefinitely (no timeout).
- DONE: done = 1 for exactly one cycle, busy = 0 in the same cycle, then IDLE.
- Address arithmetic is modulo 2^addr_bw; base + count wraps silently (e.g. 2047+1 -> 0).
- start while busy is ignored; the latched config cannot change mid-tile.

Test Plan:
- Reset check: reset low mid-EXEC -> inst returns to the IDLE value (bits 18, 19, 31, 32, 44, 45 set) without waiting for clk; busy = 0; a fresh start afterwards runs a full tile.
- Nominal tile: row=col=8, len=4, w_base=0, x_base=8, p_base=0, acc_en=0, relu_en=1, OFIFO model asserts valid 2 cycles after EXEC.
  - xmem addresses 0..7 then 8..11, each followed one cycle later by l0_wr.
  - 8 kernel-load cycles, a 16-cycle gap, then 4 execute cycles.
  - 4 ofifo_rd pulses, each followed by a pmem write to addresses 0..3.
  - inst[47] = 1 throughout; one done pulse.
- Drain backpressure: ofifo_valid toggles 1,0,0,1,1,0,1 -> ofifo_rd mirrors valid for 4 reads only; pmem writes stay exactly one cycle behind each read; done follows the 4th write.
- Zero length: start with len=0 -> done high on the second cycle; no CEN low, no l0_wr/l0_rd, inst[1:0] = 0 throughout.
- Wrap: x_base=2046, len=4 -> xmem A sequence 2046, 2047, 0, 1. p_base=2047 -> pmem A sequence 2047, 0, 1, 2.
- Ignored start: start pulsed during W_GAP with different bases -> tile completes using the original latched addresses; exactly one done pulse.
